randomgen_range: RTL and testbench
==================================

RANDOMGEN_RANGE -- requirements
Module: randomgen_range

Interface
REQ-001 Parameter WIDTH, default 10, LFSR/output width; legal values 8, 10, 12, 16 only.
REQ-002 Parameter SEED, default 1, LFSR value after reset; zero is illegal (elaboration error).
REQ-003 Parameter MAX_TRY, default 16, maximum rejection-sampling draws per request (1..255).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  LFSR advances one step per cycle while high; holds while low.
REQ-007 seed_load  input  1  load seed into LFSR this cycle (priority over en).
REQ-008 seed  input  WIDTH  value loaded by seed_load.
REQ-009 rand_num  output  WIDTH  raw LFSR state, registered.
REQ-010 req  input  1  request one ranged value; sampled only in IDLE.
REQ-011 limit  input  WIDTH  inclusive upper bound, captured on accepted req.
REQ-012 busy  output  1  high in DRAW state.
REQ-013 valid  output  1  one-cycle pulse, value is valid.
REQ-014 value  output  WIDTH  ranged result, held until next valid.
REQ-015 exhausted  output  1  qualifies valid: result came from fallback path.
REQ-016 hit_target  input  WIDTH  compare value for hit counter.
REQ-017 hit_count  output  16  count of valid results equal to hit_target.

Function
REQ-018 LFSR SHALL be Fibonacci, next = {lfsr[WIDTH-2:0], fb}, fb = XOR of tap bits (0-based): W8 {7,5,4,3}; W10 {9,6}; W12 {11,5,3,0}; W16 {15,14,12,3}; period 2^WIDTH-1.
REQ-019 seed_load with seed==0 SHALL load 1 (zero lock-up never reachable).
REQ-020 FSM states IDLE, DRAW, DONE; IDLE->DRAW on req; DRAW->DONE on accept or try count == MAX_TRY; DONE->IDLE unconditionally.
REQ-021 mask = smallest 2^k-1 >= captured limit (limit 0 -> mask 0); candidate = rand_num & mask each DRAW cycle.
REQ-022 candidate <= limit SHALL be accepted: value=candidate, exhausted=0.
REQ-023 After MAX_TRY rejections, value = candidate & (mask>>1), exhausted=1 (always <= limit).
REQ-024 valid SHALL assert in DONE only, exactly one cycle; latency req->valid = draws+1 cycles (min 2).
REQ-025 req outside IDLE SHALL be ignored; limit changes after capture SHALL have no effect.
REQ-026 en low during DRAW SHALL freeze candidate; draws still count toward MAX_TRY.
REQ-027 hit_count SHALL increment on valid when value==hit_target, saturating at 16'hFFFF.

Reset
REQ-028 rst SHALL give lfsr=SEED, state IDLE, valid=0, busy=0, exhausted=0, value=0, hit_count=0, try counter=0.
REQ-029 rst mid-DRAW SHALL abort the request with no valid pulse; rst overrides seed_load.

Configuration
REQ-030 Macro RANDOMGEN_HIT_COUNT_EN: defined -> hit counter per REQ-027; undefined -> hit_count tied 0, comparator and counter absent, hit_target unused.

Verification
REQ-031 WIDTH=10, SEED=1, en=1 after rst -> rand_num 0x002, 0x004, 0x008 on first three cycles; 0x081 on cycle 7.
REQ-032 Free-run 1023 cycles from SEED=1 -> rand_num returns to 0x001, never 0 in between.
REQ-033 seed_load=1, seed=0 -> rand_num=0x001 next cycle.
REQ-034 limit=5, 1000 requests -> every value in 0..5, valid width 1 cycle, busy low in IDLE/DONE.
REQ-035 MAX_TRY=1, limit=4, rand_num masked candidate 7 at draw -> value=3, exhausted=1.
REQ-036 Macro defined, hit_target=0, limit=0, 3 requests -> hit_count=3; macro undefined -> hit_count=0.

Source files
------------

// File: rtl/randomgen_range.sv
// ============================================================================
// Module      : randomgen_range
// Description : Fibonacci LFSR with a rejection-sampling front end that returns
//               values in 0..limit. Optional hit counter: RANDOMGEN_HIT_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module randomgen_range #(
    parameter int WIDTH   = 10,
    parameter int SEED    = 1,
    parameter int MAX_TRY = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               seed_load,
    input  logic [WIDTH-1:0]   seed,
    output logic [WIDTH-1:0]   rand_num,
    input  logic               req,
    input  logic [WIDTH-1:0]   limit,
    output logic               busy,
    output logic               valid,
    output logic [WIDTH-1:0]   value,
    output logic               exhausted,
    input  logic [WIDTH-1:0]   hit_target,
    output logic [15:0]        hit_count
);

    if (!(WIDTH == 8 || WIDTH == 10 || WIDTH == 12 || WIDTH == 16)) begin : g_bad_width
        $error("randomgen_range: WIDTH must be 8, 10, 12 or 16");
    end
    if (SEED == 0) begin : g_bad_seed
        $error("randomgen_range: SEED must be non-zero");
    end
    if (MAX_TRY < 1 || MAX_TRY > 255) begin : g_bad_max_try
        $error("randomgen_range: MAX_TRY must be 1..255");
    end

    localparam logic [15:0] C_TAPS_ALL = (WIDTH == 8)  ? 16'h00B8 :
                                         (WIDTH == 10) ? 16'h0240 :
                                         (WIDTH == 12) ? 16'h0829 :
                                                         16'hD008;
    localparam logic [WIDTH-1:0] C_TAPS     = C_TAPS_ALL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] C_SEED     = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] C_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [7:0]       C_LAST_TRY = 8'(MAX_TRY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   lfsr_q, lfsr_d;
    logic [WIDTH-1:0]   limit_q, limit_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic [7:0]         try_q, try_d;
    logic [WIDTH-1:0]   value_q, value_d;
    logic               valid_q, valid_d;
    logic               exhausted_q, exhausted_d;
    logic [WIDTH-1:0]   candidate;

    // Smear the highest set bit downward: smallest 2^k-1 covering x.
    function automatic logic [WIDTH-1:0] cover_mask(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] m;
        m = x;
        for (int i = 0; i < WIDTH; i++) begin
            m = m | (m >> 1);
        end
        return m;
    endfunction

    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load) begin
            lfsr_d = (seed == '0) ? C_ONE : seed;
        end else if (en) begin
            lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & C_TAPS)};
        end
    end

    assign candidate = lfsr_q & mask_q;

    always_comb begin
        state_d     = state_q;
        limit_d     = limit_q;
        mask_d      = mask_q;
        try_d       = try_q;
        value_d     = value_q;
        valid_d     = 1'b0;
        exhausted_d = exhausted_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    limit_d = limit;
                    mask_d  = cover_mask(limit);
                    try_d   = 8'd0;
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                if (candidate <= limit_q) begin
                    value_d     = candidate;
                    exhausted_d = 1'b0;
                    valid_d     = 1'b1;
                    try_d       = 8'd0;
                    state_d     = S_DONE;
                end else if (try_q == C_LAST_TRY) begin
                    // Dropping the top mask bit guarantees a result below limit.
                    value_d     = candidate & (mask_q >> 1);
                    exhausted_d = 1'b1;
                    valid_d     = 1'b1;
                    try_d       = 8'd0;
                    state_d     = S_DONE;
                end else begin
                    try_d = try_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lfsr_q      <= C_SEED;
            limit_q     <= '0;
            mask_q      <= '0;
            try_q       <= 8'd0;
            value_q     <= '0;
            valid_q     <= 1'b0;
            exhausted_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            limit_q     <= limit_d;
            mask_q      <= mask_d;
            try_q       <= try_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            exhausted_q <= exhausted_d;
        end
    end

    assign rand_num  = lfsr_q;
    assign busy      = (state_q == S_DRAW);
    assign valid     = valid_q;
    assign value     = value_q;
    assign exhausted = exhausted_q;

`ifdef RANDOMGEN_HIT_COUNT_EN
    logic [15:0] hit_q, hit_d;

    always_comb begin
        hit_d = hit_q;
        if (valid_q && (value_q == hit_target) && (hit_q != 16'hFFFF)) begin
            hit_d = hit_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q <= 16'd0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_count = hit_q;
`else
    logic unused_hit_target;
    assign unused_hit_target = ^hit_target;
    assign hit_count         = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_randomgen_range.sv
// ============================================================================
// Module      : tb_randomgen_range
// Description : Scoreboard bench for randomgen_range (WIDTH=10, SEED=1, MAX_TRY=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_randomgen_range;

    localparam int W = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          seed_load;
    logic [W-1:0]  seed;
    logic [W-1:0]  rand_num;
    logic          req;
    logic [W-1:0]  limit;
    logic          busy;
    logic          valid;
    logic [W-1:0]  value;
    logic          exhausted;
    logic [W-1:0]  hit_target;
    logic [15:0]   hit_count;

    always #5 clk = ~clk;

    randomgen_range #(.WIDTH(W), .SEED(1), .MAX_TRY(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .seed_load  (seed_load),
        .seed       (seed),
        .rand_num   (rand_num),
        .req        (req),
        .limit      (limit),
        .busy       (busy),
        .valid      (valid),
        .value      (value),
        .exhausted  (exhausted),
        .hit_target (hit_target),
        .hit_count  (hit_count)
    );

    typedef struct {
        logic [W-1:0] val;
        logic         exh;
        bit           exact;
        logic [W-1:0] lim;
        int           issue;
        int           lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   hits  = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (valid) begin
            chk("valid_width", {31'd0, prev_valid}, 32'd0);
            chk("busy_in_done", {31'd0, busy}, 32'd0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got value %0h expected no valid", value);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.exact) begin
                    chk("value", {22'd0, value}, {22'd0, mon_e.val});
                    chk("exhausted", {31'd0, exhausted}, {31'd0, mon_e.exh});
                    chk("latency", cyc - mon_e.issue, mon_e.lat);
                end else begin
                    total++;
                    if (value > mon_e.lim || (cyc - mon_e.issue) < 2 || (cyc - mon_e.issue) > 17) begin
                        bad++;
                        $display("FAIL range: got value %0h latency %0d expected <= %0h latency 2..17",
                                 value, cyc - mon_e.issue, mon_e.lim);
                    end
                end
            end
            if (value == hit_target) hits++;
        end
        prev_valid = valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input bit load, input logic [W-1:0] sv, input logic [W-1:0] lim,
                          input logic [W-1:0] ev, input logic eexh, input int elat,
                          input bit exact, input bit poke);
        if (load) begin
            seed_load = 1'b1;
            seed      = sv;
            tick();
            seed_load = 1'b0;
        end
        req   = 1'b1;
        limit = lim;
        sb.push_back('{ev, eexh, exact, lim, cyc, elat});
        tick();
        req   = 1'b0;
        limit = ~lim;
        if (exact) chk("busy_in_draw", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 40 && !valid; k++) begin
            req   = poke && (k >= 2) && (k < 5);
            limit = (req) ? '0 : ~lim;
            tick();
        end
        req = 1'b0;
        if (!valid) begin
            total++;
            bad++;
            $display("FAIL timeout: got no valid expected valid within 40 cycles");
        end
        tick();
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [W-1:0] sv;
        logic [W-1:0] lim;
        logic [W-1:0] ev;
        logic         eexh;
        int           elat;
        bit           poke;
    } vec_t;

    vec_t vecs[$];
    logic [W-1:0] model;

    initial begin
        rst = 1'b1; en = 1'b0; seed_load = 1'b0; seed = '0;
        req = 1'b0; limit = '0; hit_target = '0;
        repeat (2) tick();
        chk("rst_rand_num", {22'd0, rand_num}, 32'h1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_value", {22'd0, value}, 32'd0);
        chk("rst_exhausted", {31'd0, exhausted}, 32'd0);
        chk("rst_hit_count", {16'd0, hit_count}, 32'd0);

        // Free run: one full period back to the seed.
        rst = 1'b0; en = 1'b1; model = 10'h001;
        for (int i = 1; i <= 1023; i++) begin
            tick();
            model = {model[8:0], model[9] ^ model[6]};
            chk("lfsr_step", {22'd0, rand_num}, {22'd0, model});
            if (rand_num == '0) chk("lfsr_nonzero", {22'd0, rand_num}, 32'h1);
            if (i == 1) chk("lfsr_c1", {22'd0, rand_num}, 32'h002);
            if (i == 2) chk("lfsr_c2", {22'd0, rand_num}, 32'h004);
            if (i == 3) chk("lfsr_c3", {22'd0, rand_num}, 32'h008);
            if (i == 7) chk("lfsr_c7", {22'd0, rand_num}, 32'h081);
        end
        chk("lfsr_period", {22'd0, rand_num}, 32'h001);

        seed_load = 1'b1; seed = '0;
        tick();
        chk("seed_zero", {22'd0, rand_num}, 32'h001);
        seed = 10'h155;
        tick();
        chk("seed_over_en", {22'd0, rand_num}, 32'h155);
        seed_load = 1'b0; en = 1'b0;
        tick();
        chk("en_hold", {22'd0, rand_num}, 32'h155);

        // Frozen-LFSR directed draws: seed, limit, value, exhausted, latency, poke.
        vecs.push_back('{10'h005, 10'h005, 10'h005, 1'b0, 2,  1'b0});
        vecs.push_back('{10'h3FC, 10'h003, 10'h000, 1'b0, 2,  1'b0});
        vecs.push_back('{10'h00F, 10'h009, 10'h007, 1'b1, 17, 1'b1});
        vecs.push_back('{10'h007, 10'h004, 10'h003, 1'b1, 17, 1'b0});
        vecs.push_back('{10'h2AB, 10'h000, 10'h000, 1'b0, 2,  1'b0});
        vecs.push_back('{10'h001, 10'h000, 10'h000, 1'b0, 2,  1'b0});
        vecs.push_back('{10'h3FF, 10'h000, 10'h000, 1'b0, 2,  1'b0});
        vecs.push_back('{10'h155, 10'h3FF, 10'h155, 1'b0, 2,  1'b0});
        vecs.push_back('{10'h200, 10'h1FF, 10'h000, 1'b0, 2,  1'b0});
        vecs.push_back('{10'h0C8, 10'h0C8, 10'h0C8, 1'b0, 2,  1'b0});
        vecs.push_back('{10'h0C9, 10'h0C8, 10'h049, 1'b1, 17, 1'b0});
        vecs.push_back('{10'h3F0, 10'h100, 10'h0F0, 1'b1, 17, 1'b0});
        foreach (vecs[i]) begin
            do_req(1'b1, vecs[i].sv, vecs[i].lim, vecs[i].ev, vecs[i].eexh,
                   vecs[i].elat, 1'b1, vecs[i].poke);
        end

        en = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            do_req(1'b0, '0, 10'h005, '0, 1'b0, 0, 1'b0, 1'b0);
        end

        repeat (2) tick();
`ifdef RANDOMGEN_HIT_COUNT_EN
        chk("hit_count", {16'd0, hit_count}, hits);
`else
        chk("hit_count", {16'd0, hit_count}, 32'd0);
`endif

        // Reset during a long draw: no valid, seed_load overridden.
        en = 1'b0;
        seed_load = 1'b1; seed = 10'h00F;
        tick();
        seed_load = 1'b0; req = 1'b1; limit = 10'h009;
        tick();
        req = 1'b0;
        repeat (5) tick();
        rst = 1'b1; seed_load = 1'b1; seed = 10'h155;
        tick();
        chk("rst_mid_rand", {22'd0, rand_num}, 32'h001);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0; seed_load = 1'b0;
        repeat (20) tick();
        chk("rst_mid_value", {22'd0, value}, 32'd0);
        chk("rst_mid_hits", {16'd0, hit_count}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
